hazard_scoreboard_ctrl: RTL

HAZARD_SCOREBOARD_CTRL -- requirements
Module: hazard_scoreboard_ctrl

---
 rtl/hazard_scoreboard_ctrl_if.sv | 33 +++
 rtl/hazard_scoreboard_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID-stage hazard control bundle: decoded ID operands and pipeline controls in,
// stall/bubble/flush/issue decisions and statistics out.
interface hazard_scoreboard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid_i;
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic [4:0]       id_rd_addr_i;
    logic             id_rd_wren_i;
    logic             hold_i;
    logic             flush_i;
    logic             stall_o;
    logic             bubble_o;
    logic             flush_o;
    logic             issue_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        output id_rd_addr_i, id_rd_wren_i, hold_i, flush_i,
        input  stall_o, bubble_o, flush_o, issue_o, state_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
        input  id_rd_addr_i, id_rd_wren_i, hold_i, flush_i,
        output stall_o, bubble_o, flush_o, issue_o, state_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// In-order pipeline hazard scoreboard: tracks EX/MEM/WB destinations and decides
// whether the ID instruction issues, stalls behind a RAW dependence, or is flushed.
module hazard_scoreboard_ctrl #(
    parameter bit          REGFILE_BYPASS = 1'b0,
    parameter int unsigned CNT_W          = 16
) (
    input logic                     clk_i,
    input logic                     rst_i,
    hazard_scoreboard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StStall = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             ex_vld_q, ex_vld_d;
    logic             mem_vld_q, mem_vld_d;
    logic             wb_vld_q, wb_vld_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs1_hit, rs2_hit, hazard;
    logic stall, bubble, flush, issue;

    // WB is ignored when the register file forwards its own write data.
    assign rs1_hit = bus.id_rs1_used_i && (bus.id_rs1_addr_i != 5'd0) &&
                     ((ex_vld_q && (ex_rd_q == bus.id_rs1_addr_i)) ||
                      (mem_vld_q && (mem_rd_q == bus.id_rs1_addr_i)) ||
                      (!REGFILE_BYPASS && wb_vld_q && (wb_rd_q == bus.id_rs1_addr_i)));
    assign rs2_hit = bus.id_rs2_used_i && (bus.id_rs2_addr_i != 5'd0) &&
                     ((ex_vld_q && (ex_rd_q == bus.id_rs2_addr_i)) ||
                      (mem_vld_q && (mem_rd_q == bus.id_rs2_addr_i)) ||
                      (!REGFILE_BYPASS && wb_vld_q && (wb_rd_q == bus.id_rs2_addr_i)));
    assign hazard  = rs1_hit || rs2_hit;

    always_comb begin
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        issue   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.hold_i) begin
            stall = 1'b1;
        end else if (bus.flush_i) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = StFlush;
        end else if (state_q == StFlush) begin
            // The instruction sitting in IF/ID was fetched down the wrong path.
            bubble  = 1'b1;
            state_d = StRun;
        end else if (!bus.id_valid_i) begin
            bubble  = 1'b1;
            state_d = StRun;
        end else if (hazard) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = StStall;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            issue   = 1'b1;
            state_d = StRun;
        end
    end

    always_comb begin
        ex_vld_d  = ex_vld_q;
        ex_rd_d   = ex_rd_q;
        mem_vld_d = mem_vld_q;
        mem_rd_d  = mem_rd_q;
        wb_vld_d  = wb_vld_q;
        wb_rd_d   = wb_rd_q;
        if (!bus.hold_i) begin
            wb_vld_d  = mem_vld_q;
            wb_rd_d   = mem_rd_q;
            mem_vld_d = ex_vld_q;
            mem_rd_d  = ex_rd_q;
            ex_vld_d  = issue && bus.id_rd_wren_i && (bus.id_rd_addr_i != 5'd0);
            ex_rd_d   = bus.id_rd_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StRun;
            ex_vld_q  <= 1'b0;
            ex_rd_q   <= 5'd0;
            mem_vld_q <= 1'b0;
            mem_rd_q  <= 5'd0;
            wb_vld_q  <= 1'b0;
            wb_rd_q   <= 5'd0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ex_vld_q  <= ex_vld_d;
            ex_rd_q   <= ex_rd_d;
            mem_vld_q <= mem_vld_d;
            mem_rd_q  <= mem_rd_d;
            wb_vld_q  <= wb_vld_d;
            wb_rd_q   <= wb_rd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.bubble_o    = bubble;
    assign bus.flush_o     = flush;
    assign bus.issue_o     = issue;
    assign bus.state_o     = state_q;
    assign bus.stall_cnt_o = cnt_q;

endmodule
